// File: rtl/bus_arb_n.sv
// N-channel Wishbone-classic read arbiter: fixed-priority or round-robin selection onto one
// downstream slave, with one-hot grant, abort tracking and an optional per-transaction timeout.
//
// state | meaning
// IDLE  | no owner; grant = 0; any request is arbitrated on the next edge
// GRANT | owner holds the slave; returns to IDLE on ack, owner abort or timeout
module bus_arb_n #(
   parameter int N       = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 0
) (
   input  logic            wb_clk,
   input  logic            wb_rst_n,
   input  logic [N-1:0]    m_cyc,
   input  logic [N*AW-1:0] m_adr,
   output logic [N-1:0]    m_ack,
   output logic [N*DW-1:0] m_rdt,
   output logic [N-1:0]    m_err,
   output logic            x_cyc,
   output logic [AW-1:0]   x_adr,
   input  logic            x_ack,
   input  logic [DW-1:0]   x_rdt,
   output logic [N-1:0]    grant,
   output logic            busy
);

   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] owner;
   logic [OW-1:0] ptr;
   logic [OW-1:0] win;
   logic          win_vld;
   logic [CW-1:0] cnt;
   logic          expire;

   // Iterate from lowest to highest precedence so the last hit wins.
   always_comb begin
      win     = '0;
      win_vld = |m_cyc;
      if (MODE == 0) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (m_cyc[i]) win = OW'(i);
         end
      end else begin
         for (int j = N; j >= 1; j--) begin
            if (m_cyc[(int'(ptr) + j) % N]) win = OW'((int'(ptr) + j) % N);
         end
      end
   end

   assign busy   = (state == GRANT);
   assign x_cyc  = (state == GRANT) && m_cyc[owner];
   assign expire = (TIMEOUT > 0) && (cnt == CNT_LAST);

   // Ack beats a simultaneous expiry; an aborted owner gets neither.
   always_comb begin
      m_ack = '0;
      m_err = '0;
      m_rdt = '0;
      if (x_cyc && x_ack) begin
         m_ack[owner]                   = 1'b1;
         m_rdt[int'(owner) * DW +: DW]  = x_rdt;
      end else if (x_cyc && expire) begin
         m_err[owner] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = GRANT;
         GRANT:   if (!x_cyc || x_ack || expire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         x_adr <= '0;
         cnt   <= '0;
         ptr   <= OW'(N - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (win_vld) begin
               grant <= {{(N-1){1'b0}}, 1'b1} << win;
               owner <= win;
               x_adr <= m_adr[int'(win) * AW +: AW];
               cnt   <= '0;
               ptr   <= win;
            end
         end else begin
            if (state_nxt == IDLE) begin
               grant <= '0;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule
